// File: rtl/cphy_lp_pkg.sv
// Shared C-PHY LP definitions: sequencer state encoding and trio LP levels.
// Also used by the receive-side LP state decoder, so keep encodings stable.
package cphy_lp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TA_GET    = 3'd1,
    ST_TA_ACK    = 3'd2,
    ST_TA_PRE    = 3'd3,
    ST_STOP      = 3'd4,
    ST_STOP_HOLD = 3'd5
  } lp_tx_state_t;

  // Trio levels packed as {A,B,C}
  localparam logic [2:0] LP_000 = 3'b000;
  localparam logic [2:0] LP_100 = 3'b100;
  localparam logic [2:0] LP_111 = 3'b111;

  // Level a state drives on the trio (IDLE reports 111 with drivers off)
  function automatic logic [2:0] lpLevel(lp_tx_state_t s);
    case (s)
      ST_TA_GET, ST_TA_PRE: lpLevel = LP_000;
      ST_TA_ACK:            lpLevel = LP_100;
      default:              lpLevel = LP_111;
    endcase
  endfunction

  // States with a TLPX-based duration
  function automatic logic isTimed(lp_tx_state_t s);
    return s inside {ST_TA_GET, ST_TA_ACK, ST_TA_PRE, ST_STOP};
  endfunction

endpackage

// File: rtl/lp_tx_turnaround_seq_if.sv
// Handshake/pad bundle between lane control, contention detector and the
// LP turnaround sequencer. master = lane-control side, slave = sequencer.
interface lp_tx_turnaround_seq_if;
  logic TurnReq;
  logic Release;
  logic ErrContentionP0;
  logic ErrContentionP1;
  logic LpTxA;
  logic LpTxB;
  logic LpTxC;
  logic LpTxEn;
  logic TurnAck;
  logic TurnDone;
  logic Busy;
  logic ErrContention;

  modport master (
    output TurnReq, Release, ErrContentionP0, ErrContentionP1,
    input  LpTxA, LpTxB, LpTxC, LpTxEn, TurnAck, TurnDone, Busy, ErrContention
  );

  modport slave (
    input  TurnReq, Release, ErrContentionP0, ErrContentionP1,
    output LpTxA, LpTxB, LpTxC, LpTxEn, TurnAck, TurnDone, Busy, ErrContention
  );
endinterface

// File: rtl/lp_tlpx_timer.sv
// State duration down-counter plus contention blanking counter.
// Both saturate at zero; zero flags are decoded from the registers.
module lp_tlpx_timer #(
  parameter int CNT_W    = 8,
  parameter int CD_BLANK = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             blankRestart,
  output logic             timerZero,
  output logic             blankZero
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] blank;

  // State timer: load on state entry, otherwise count down to zero
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                cnt <= '0;
    else if (load)          cnt <= loadVal;
    else if (cnt != '0)     cnt <= cnt - CNT_W'(1);
  end

  // Blank window: reopened on every LP level change
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                blank <= '0;
    else if (blankRestart)  blank <= CNT_W'(CD_BLANK);
    else if (blank != '0)   blank <= blank - CNT_W'(1);
  end

  assign timerZero = (cnt == '0);
  assign blankZero = (blank == '0);

endmodule

// File: rtl/lp_tx_turnaround_seq.sv
// Slave-side C-PHY LP turnaround handback: TA-Get -> TA-Ack -> TA-Pre -> Stop.
// Optional feature macro: LPTX_CONTENTION_ABORT_EN (contention aborts to IDLE).
// All outputs are registered from the next-state decode so levels switch on
// the same edge as the state.
module lp_tx_turnaround_seq
  import cphy_lp_pkg::*;
#(
  parameter int TLPX_CYCLES = 8,
  parameter int TA_GET_MULT = 5,
  parameter int CD_BLANK    = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  lp_tx_turnaround_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] GET_LOAD  = CNT_W'(TLPX_CYCLES * TA_GET_MULT - 1);
  localparam logic [CNT_W-1:0] TLPX_LOAD = CNT_W'(TLPX_CYCLES - 1);

  lp_tx_state_t     state, stateNext;
  logic             timerZero, blankZero, contHit, enterTimed;
  logic [CNT_W-1:0] loadVal;
  logic [2:0]       lvlD;
  logic             enD, ackD, doneD, busyD, errD;

  // Contention only counts while driving and outside the blank window
  assign contHit    = bus.LpTxEn & blankZero & (bus.ErrContentionP0 | bus.ErrContentionP1);
  // Every timed-state entry is also an LP level change
  assign enterTimed = (stateNext != state) && isTimed(stateNext);
  assign loadVal    = (stateNext == ST_TA_GET) ? GET_LOAD : TLPX_LOAD;

  lp_tlpx_timer #(.CNT_W(CNT_W), .CD_BLANK(CD_BLANK)) uTimer (
    .Clk          (Clk),
    .Rst          (Rst),
    .load         (enterTimed),
    .loadVal      (loadVal),
    .blankRestart (enterTimed),
    .timerZero    (timerZero),
    .blankZero    (blankZero)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  // Next-state decode; timed states leave when the timer reads zero
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:      if (bus.TurnReq) stateNext = ST_TA_GET;
      ST_TA_GET:    if (timerZero)   stateNext = ST_TA_ACK;
      ST_TA_ACK:    if (timerZero)   stateNext = ST_TA_PRE;
      ST_TA_PRE:    if (timerZero)   stateNext = ST_STOP;
      ST_STOP:      if (timerZero)   stateNext = ST_STOP_HOLD;
      ST_STOP_HOLD: if (bus.Release) stateNext = ST_IDLE;
      default:                       stateNext = ST_IDLE;
    endcase
`ifdef LPTX_CONTENTION_ABORT_EN
    if (contHit) stateNext = ST_IDLE;
`endif
  end

  // Output decode from the upcoming state
  always_comb begin
    lvlD  = lpLevel(stateNext);
    enD   = (stateNext != ST_IDLE);
    busyD = (stateNext != ST_IDLE);
    ackD  = (state == ST_IDLE) && (stateNext == ST_TA_GET);
    doneD = (state == ST_STOP) && (stateNext == ST_STOP_HOLD);
    errD  = ackD ? 1'b0 : (bus.ErrContention | contHit);
  end

  // Output registers; reset tri-states the drivers immediately
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bus.LpTxA         <= 1'b1;
      bus.LpTxB         <= 1'b1;
      bus.LpTxC         <= 1'b1;
      bus.LpTxEn        <= 1'b0;
      bus.TurnAck       <= 1'b0;
      bus.TurnDone      <= 1'b0;
      bus.Busy          <= 1'b0;
      bus.ErrContention <= 1'b0;
    end else begin
      bus.LpTxA         <= lvlD[2];
      bus.LpTxB         <= lvlD[1];
      bus.LpTxC         <= lvlD[0];
      bus.LpTxEn        <= enD;
      bus.TurnAck       <= ackD;
      bus.TurnDone      <= doneD;
      bus.Busy          <= busyD;
      bus.ErrContention <= errD;
    end
  end

endmodule

// File: tb/tb_lp_tx_turnaround_seq.sv
// Bench for lp_tx_turnaround_seq: schedule-based reference model plus
// directed literal checks, randomized traffic, and a short-timing instance.
module tb_lp_tx_turnaround_seq;

  localparam int G    = 40;        // TA-Get cycles (8*5)
  localparam int T    = 8;         // TLPX cycles
  localparam int CD   = 2;
  localparam int HOLD = G + 3*T + 1; // cycle index of STOP_HOLD entry

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   cnt = 0;
  int   t0  = 0;
  int   nCmp = 0;
  int   nFail = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cnt <= cnt + 1;

  lp_tx_turnaround_seq_if bus();
  lp_tx_turnaround_seq_if bus2();

  lp_tx_turnaround_seq dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  lp_tx_turnaround_seq #(.TLPX_CYCLES(2), .TA_GET_MULT(1), .CD_BLANK(1), .CNT_W(8))
    dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2));

  // ---------------- reference model ----------------
  // k = cycles since acceptance (0 = idle); the phase follows from k alone.
  typedef struct {
    int         k;
    logic [2:0] lvl;
    logic       en, ack, done, busy, err;
  } mst_t;

  mst_t m;

  function automatic int lvlStart(int k);
    if (k <= G)       return 1;
    if (k <= G + T)   return G + 1;
    if (k <= G + 2*T) return G + T + 1;
    return G + 2*T + 1;               // STOP and STOP_HOLD share level 111
  endfunction

  function automatic logic [2:0] lvlOf(int k);
    if (k == 0)       return 3'b111;
    if (k <= G)       return 3'b000;
    if (k <= G + T)   return 3'b100;
    if (k <= G + 2*T) return 3'b000;
    return 3'b111;
  endfunction

  function automatic mst_t mReset();
    mst_t r;
    r.k = 0; r.lvl = 3'b111; r.en = 0; r.ack = 0; r.done = 0; r.busy = 0; r.err = 0;
    return r;
  endfunction

  function automatic mst_t mStep(mst_t s, logic req, logic relIn, logic p0, logic p1);
    mst_t n;
    logic hit;
    n = s; n.ack = 0; n.done = 0;
    hit = s.en && (s.k - lvlStart(s.k) >= CD) && (p0 | p1);
    if (s.k == 0) begin
      if (req) begin n.k = 1; n.ack = 1; n.err = 0; end
    end else if (s.k == HOLD) begin
      if (relIn) n.k = 0;
    end else begin
      n.k = s.k + 1;
      if (n.k == HOLD) n.done = 1;
    end
    if (hit) n.err = 1;
`ifdef LPTX_CONTENTION_ABORT_EN
    if (hit) begin n.k = 0; n.done = 0; end
`endif
    n.en = (n.k != 0); n.busy = n.en; n.lvl = lvlOf(n.k);
    return n;
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) m <= mReset();
    else     m <= mStep(m, bus.TurnReq, bus.Release, bus.ErrContentionP0, bus.ErrContentionP1);
  end

  // ---------------- checking helpers ----------------
  task automatic cmpModel();
    logic [7:0] act, exp;
    act = {bus.LpTxA, bus.LpTxB, bus.LpTxC, bus.LpTxEn, bus.TurnAck, bus.TurnDone, bus.Busy, bus.ErrContention};
    exp = {m.lvl, m.en, m.ack, m.done, m.busy, m.err};
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL model cyc=%0d got ABC/En/Ack/Done/Busy/Err=%b expected %b", cnt, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare at the falling edge, then move off it to drive inputs
  task automatic nextCyc();
    @(negedge Clk);
    cmpModel();
    #1;
  endtask

  function automatic int rel();
    return cnt - t0;
  endfunction

  // Advance to cycle r of the current sequence, noting the first TurnDone
  task automatic runTo(input int r, output int dr);
    int n;
    n = 0; dr = -1;
    while (rel() < r && n < 500) begin
      if (bus.TurnDone && dr < 0) dr = rel();
      nextCyc(); n++;
    end
    if (bus.TurnDone && dr < 0) dr = rel();
  endtask

  task automatic goIdle();
    int n;
    n = 0;
    bus.Release = 1;
    while (bus.Busy && n < 200) begin nextCyc(); n++; end
    bus.Release = 0;
    if (n >= 200) check("idleTimeout", 1, 0);
    nextCyc();
  endtask

  task automatic startSeq();
    bus.TurnReq = 1; t0 = cnt;
    nextCyc();
    bus.TurnReq = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] exp2 [1:8];
  int         doneRel;
  logic       sawDone;

  initial begin
    exp2 = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b111, 3'b111};
    bus.TurnReq = 0; bus.Release = 0; bus.ErrContentionP0 = 0; bus.ErrContentionP1 = 0;
    bus2.TurnReq = 0; bus2.Release = 0; bus2.ErrContentionP0 = 0; bus2.ErrContentionP1 = 0;

    // Reset state
    repeat (3) nextCyc();
    check("rstLvl",  {bus.LpTxA, bus.LpTxB, bus.LpTxC}, 3'b111);
    check("rstEn",   bus.LpTxEn, 0);
    check("rstFlags", {bus.TurnAck, bus.TurnDone, bus.Busy, bus.ErrContention}, 4'b0000);
    Rst = 0;
    nextCyc();

    // Clean sequence with literal schedule points
    startSeq();
    check("ack@1",  bus.TurnAck, 1);
    check("busy@1", bus.Busy, 1);
    check("lvl@1",  {bus.LpTxEn, bus.LpTxA, bus.LpTxB, bus.LpTxC}, 4'b1000);
    doneRel = -1;
    for (int r = 1; r <= 70; r++) begin
      if (bus.TurnDone && doneRel < 0) doneRel = rel();
      case (rel())
        40: check("lvl@40", {bus.LpTxEn, bus.LpTxA, bus.LpTxB, bus.LpTxC}, 4'b1000);
        41: check("lvl@41", {bus.LpTxEn, bus.LpTxA, bus.LpTxB, bus.LpTxC}, 4'b1100);
        48: check("lvl@48", {bus.LpTxEn, bus.LpTxA, bus.LpTxB, bus.LpTxC}, 4'b1100);
        49: check("lvl@49", {bus.LpTxEn, bus.LpTxA, bus.LpTxB, bus.LpTxC}, 4'b1000);
        57: check("lvl@57", {bus.LpTxEn, bus.LpTxA, bus.LpTxB, bus.LpTxC}, 4'b1111);
        default: ;
      endcase
      nextCyc();
    end
    check("doneCycle", doneRel, 65);

    // TurnReq in STOP_HOLD is ignored; Release drops drivers one cycle later
    bus.TurnReq = 1;
    for (int i = 0; i < 3; i++) begin
      nextCyc();
      check("holdBusy", bus.Busy, 1);
      check("holdNoAck", bus.TurnAck, 0);
    end
    bus.TurnReq = 0; bus.Release = 1;
    nextCyc();
    bus.Release = 0;
    check("relEn",   bus.LpTxEn, 0);
    check("relBusy", bus.Busy, 0);
    nextCyc();

    // Contention inside the blank window is ignored, outside it is latched
    startSeq();
    runTo(41, doneRel);
    bus.ErrContentionP1 = 1;
    nextCyc();
    bus.ErrContentionP1 = 0;
    check("blankIgnore", bus.ErrContention, 0);
    nextCyc();
    bus.ErrContentionP1 = 1;
    nextCyc();
    bus.ErrContentionP1 = 0;
    check("errSet", bus.ErrContention, 1);
`ifdef LPTX_CONTENTION_ABORT_EN
    check("abortBusy", bus.Busy, 0);
    check("abortEn",   bus.LpTxEn, 0);
`else
    runTo(70, doneRel);
    check("doneWithErr", doneRel, 65);
`endif
    goIdle();

    // P0 in TA-Get, then a new request clears the sticky flag
    startSeq();
    runTo(5, doneRel);
    bus.ErrContentionP0 = 1;
    nextCyc();
    bus.ErrContentionP0 = 0;
    check("errP0", bus.ErrContention, 1);
    goIdle();
    startSeq();
    check("ackB",   bus.TurnAck, 1);
    check("errClr", bus.ErrContention, 0);

    // Async reset in TA-Pre cycle 4
    runTo(52, doneRel);
    Rst = 1;
    #1;
    check("asyncEn",  bus.LpTxEn, 0);
    check("asyncLvl", {bus.LpTxA, bus.LpTxB, bus.LpTxC}, 3'b111);
    nextCyc(); nextCyc();
    Rst = 0;
    sawDone = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.TurnDone || bus.Busy) sawDone = 1;
      nextCyc();
    end
    check("noDoneAfterRst", sawDone, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.TurnReq         = ($urandom_range(7) == 0);
      bus.Release         = ($urandom_range(5) == 0);
      bus.ErrContentionP0 = ($urandom_range(39) == 0);
      bus.ErrContentionP1 = ($urandom_range(39) == 0);
      nextCyc();
    end
    bus.TurnReq = 0; bus.ErrContentionP0 = 0; bus.ErrContentionP1 = 0;
    goIdle();

    // Short timing instance: 2/2/2/2 cycles, TurnDone at cycle 9
    bus2.TurnReq = 1; t0 = cnt;
    nextCyc();
    bus2.TurnReq = 0;
    check("dut2Ack", bus2.TurnAck, 1);
    doneRel = -1;
    for (int r = 1; r <= 12; r++) begin
      if (bus2.TurnDone && doneRel < 0) doneRel = rel();
      if (rel() >= 1 && rel() <= 8)
        check("dut2Lvl", {bus2.LpTxEn, bus2.LpTxA, bus2.LpTxB, bus2.LpTxC}, {1'b1, exp2[rel()]});
      nextCyc();
    end
    check("dut2Done", doneRel, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
